// File: rtl/sec_monitor_pkg.sv
// rtl/sec_monitor_pkg.sv - shared types and defaults for the packet-verdict controller
package sec_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    DECIDE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W          = 16;
  localparam int DEFAULT_RECOVER_CYCLES = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - unsigned counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         core_sp_clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge core_sp_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sec_verdict_ctrl.sv
// rtl/sec_verdict_ctrl.sv - per-packet forward/drop verdict FSM with post-violation core hold
module sec_verdict_ctrl
  import sec_monitor_pkg::*;
#(
  parameter int RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic             core_sp_clk,
  input  logic             reset,
  input  logic             drop_packet,
  input  logic             pkt_start,
  input  logic             pkt_done,
  input  logic             oq_ack,
  output logic             verdict_valid,
  output logic             verdict_drop,
  output logic             core_hold,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] viol_count
);

  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RW-1:0] REC_LOAD = RW'(RECOVER_CYCLES - 1);

  state_t        state;
  logic          drop_flag;
  logic [RW-1:0] rec_cnt;
  logic          accept;

  assign accept = (state == DECIDE) && oq_ack;

  always_ff @(posedge core_sp_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      drop_flag     <= 1'b0;
      rec_cnt       <= '0;
      verdict_valid <= 1'b0;
      verdict_drop  <= 1'b0;
      core_hold     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_start) begin
            state <= MONITOR;
            busy  <= 1'b1;
          end
        end
        MONITOR: begin
          // a violation aborts the packet immediately and outranks pkt_done
          if (drop_packet || pkt_done) begin
            state         <= DECIDE;
            drop_flag     <= drop_packet;
            verdict_valid <= 1'b1;
            verdict_drop  <= drop_packet;
          end
        end
        DECIDE: begin
          if (oq_ack) begin
            verdict_valid <= 1'b0;
            verdict_drop  <= 1'b0;
            if (drop_flag) begin
              state     <= RECOVER;
              core_hold <= 1'b1;
              rec_cnt   <= REC_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        RECOVER: begin
          if (rec_cnt == '0) begin
            state     <= IDLE;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            drop_flag <= 1'b0;
          end else begin
            rec_cnt <= rec_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .core_sp_clk (core_sp_clk),
    .reset       (reset),
    .inc         (accept),
    .count       (pkt_count)
  );

  sat_counter #(.W(CNT_W)) u_viol_cnt (
    .core_sp_clk (core_sp_clk),
    .reset       (reset),
    .inc         (accept && drop_flag),
    .count       (viol_count)
  );

endmodule

// File: tb/tb_sec_verdict_ctrl.sv
// tb/tb_sec_verdict_ctrl.sv - scoreboard bench for sec_verdict_ctrl (CNT_W=4, RECOVER_CYCLES=16)
module tb_sec_verdict_ctrl;

  localparam int CW  = 4;
  localparam int REC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          drop_packet, pkt_start, pkt_done, oq_ack;
  logic          verdict_valid, verdict_drop, core_hold, busy;
  logic [CW-1:0] pkt_count, viol_count;

  int total = 0;
  int bad   = 0;
  int exp_pkt  = 0;
  int exp_viol = 0;
  bit exp_q[$];
  bit was_valid = 1'b0;
  bit held_drop = 1'b0;

  always #5 clk = ~clk;

  sec_verdict_ctrl #(.RECOVER_CYCLES(REC), .CNT_W(CW)) dut (
    .core_sp_clk   (clk),
    .reset         (reset),
    .drop_packet   (drop_packet),
    .pkt_start     (pkt_start),
    .pkt_done      (pkt_done),
    .oq_ack        (oq_ack),
    .verdict_valid (verdict_valid),
    .verdict_drop  (verdict_drop),
    .core_hold     (core_hold),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .viol_count    (viol_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: pop on the first valid cycle, then require the verdict to stay put
  always @(negedge clk) begin
    if (verdict_valid) begin
      if (!was_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_verdict", 1, 0);
        end else begin
          held_drop = exp_q.pop_front();
          chk("verdict_drop", int'(verdict_drop), int'(held_drop));
        end
      end else begin
        chk("verdict_stable", int'(verdict_drop), int'(held_drop));
      end
    end
    was_valid = verdict_valid;
  end

  function automatic int sat_inc(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, "_pkt_count"}, int'(pkt_count), exp_pkt);
    chk({tag, "_viol_count"}, int'(viol_count), exp_viol);
  endtask

  // gap: cycles from start to trigger; inject: poke drop/start mid-recovery
  task automatic run_pkt(input int gap, input bit drop, input bit both,
                         input int ack_delay, input bit inject);
    int n;
    pkt_start = 1'b1;
    cyc();
    pkt_start = 1'b0;
    repeat (gap - 1) cyc();
    drop_packet = drop;
    pkt_done    = !drop || both;
    exp_q.push_back(drop);
    cyc();
    drop_packet = 1'b0;
    pkt_done    = 1'b0;
    chk("valid_next_cycle", int'(verdict_valid), 1);
    repeat (ack_delay) cyc();
    chk("valid_before_ack", int'(verdict_valid), 1);
    oq_ack = 1'b1;
    cyc();
    oq_ack = 1'b0;
    exp_pkt = sat_inc(exp_pkt);
    if (drop) exp_viol = sat_inc(exp_viol);
    chk("valid_after_ack", int'(verdict_valid), 0);
    check_counts("after_ack");
    if (drop) begin
      n = 0;
      while (core_hold && n < 100) begin
        n++;
        if (inject && n == 5) begin
          drop_packet = 1'b1;
          pkt_start   = 1'b1;
        end else begin
          drop_packet = 1'b0;
          pkt_start   = 1'b0;
        end
        cyc();
      end
      drop_packet = 1'b0;
      pkt_start   = 1'b0;
      chk("core_hold_cycles", n, REC);
      chk("busy_after_recover", int'(busy), 0);
    end else begin
      chk("fwd_no_hold", int'(core_hold), 0);
      chk("fwd_idle", int'(busy), 0);
    end
  endtask

  initial begin
    reset = 1'b1; drop_packet = 1'b0; pkt_start = 1'b0; pkt_done = 1'b0; oq_ack = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", int'(verdict_valid), 0);
    chk("rst_hold", int'(core_hold), 0);
    chk("rst_busy", int'(busy), 0);
    check_counts("rst");
    reset = 1'b0;
    cyc();

    // clean packet
    run_pkt(5, 1'b0, 1'b0, 0, 1'b0);
    // violation mid-packet, no pkt_done
    run_pkt(3, 1'b1, 1'b0, 0, 1'b0);
    // simultaneous drop and done, ack held off 7 cycles
    run_pkt(2, 1'b1, 1'b1, 7, 1'b0);

    // ignored inputs in IDLE
    drop_packet = 1'b1; pkt_done = 1'b1;
    cyc();
    drop_packet = 1'b0; pkt_done = 1'b0;
    repeat (3) cyc();
    chk("idle_ignore_busy", int'(busy), 0);
    chk("idle_ignore_valid", int'(verdict_valid), 0);
    check_counts("idle_ignore");

    // drop and start poked during recovery must not start a packet
    run_pkt(2, 1'b1, 1'b0, 0, 1'b1);
    repeat (3) cyc();
    chk("recover_start_ignored", int'(busy), 0);
    check_counts("recover_ignore");
    // minimum-length forward packet right after
    run_pkt(1, 1'b0, 1'b0, 0, 1'b0);
    // back-to-back start on the cycle after a forward accept
    run_pkt(1, 1'b0, 1'b0, 1, 1'b0);

    // saturation: 20 more drop packets on 4-bit counters
    for (int i = 0; i < 20; i++) run_pkt(1 + (i % 3), 1'b1, i[0], i % 2, 1'b0);
    chk("sat_pkt", int'(pkt_count), 15);
    chk("sat_viol", int'(viol_count), 15);

    // reset 4 cycles into recovery
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_pkt = 0; exp_viol = 0;
    cyc();
    pkt_start = 1'b1;
    cyc();
    pkt_start = 1'b0;
    drop_packet = 1'b1;
    exp_q.push_back(1'b1);
    cyc();
    drop_packet = 1'b0;
    oq_ack = 1'b1;
    cyc();
    oq_ack = 1'b0;
    exp_pkt = 1; exp_viol = 1;
    repeat (3) cyc();
    chk("hold_before_reset", int'(core_hold), 1);
    reset = 1'b1;
    #1;
    chk("hold_async_drop", int'(core_hold), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(verdict_valid), 0);
    exp_pkt = 0; exp_viol = 0;
    check_counts("mid_reset");
    cyc();
    reset = 1'b0;
    cyc();
    run_pkt(4, 1'b0, 1'b0, 2, 1'b0);
    chk("post_reset_pkt", int'(pkt_count), 1);

    repeat (3) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
